// File: rtl/acc_job_arbiter.sv
// Round-robin arbiter and job sequencer sharing one multiply-add accelerator
// among NUM_REQ requesters, with a watchdog that aborts overlong jobs.
module acc_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int WIDTH_TIMEOUT  = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               acc_start_o,
  input  logic               acc_done_i,
  output logic               acc_abort_o,
  output logic               busy_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, RELEASE} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WIDTH_TIMEOUT-1:0] TO_LAST =
    WIDTH_TIMEOUT'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                   state, state_nxt;
  logic [ID_W-1:0]          ptr, winner, pick;
  logic                     found;
  logic [WIDTH_TIMEOUT-1:0] cnt;
  logic                     flag, expire;

  // (a + k) mod NUM_REQ with one extra bit of headroom; k never exceeds NUM_REQ-1.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
    logic [ID_W:0] s;
    s = {1'b0, a} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NUM_REQ))
      s = s - (ID_W+1)'(NUM_REQ);
    return s[ID_W-1:0];
  endfunction

  // First requester at or after ptr, wrapping; only consumed in IDLE.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[wrap_add(ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_add(ptr, k);
      end
    end
  end

  assign expire = WD_EN && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = RUN;
      RUN:     if (acc_done_i || expire) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      winner <= '0;
      cnt    <= '0;
      flag   <= 1'b0;
    end else begin
      if (state == IDLE && found)
        winner <= pick;
      if (state == GRANT)
        cnt <= '0;
      else if (state == RUN && cnt != '1)
        cnt <= cnt + 1'b1;
      // The last RUN cycle decides the flag; a simultaneous done beats expiry.
      if (state == RUN)
        flag <= !acc_done_i && expire;
      if (state == RELEASE)
        ptr <= wrap_add(winner, 1);
    end
  end

  assign busy_o      = (state != IDLE);
  assign gnt_o       = busy_o ? (NUM_REQ'(1) << winner) : '0;
  assign gnt_id_o    = busy_o ? winner : '0;
  assign acc_start_o = (state == GRANT);
  assign done_o      = (state == RELEASE) ? (NUM_REQ'(1) << winner) : '0;
  assign timeout_o   = (state == RELEASE) && flag;
  assign acc_abort_o = (state == RELEASE) && flag;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Directed bench for acc_job_arbiter: a cycle table for the basic job,
// then hand-written sequences for rotation, watchdog and reset corners.
module tb_acc_job_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_i = '0;
  logic       acc_done_i = 1'b0;
  logic [3:0] gnt_o, done_o;
  logic [1:0] gnt_id_o;
  logic       acc_start_o, acc_abort_o, busy_o, timeout_o;

  int checks = 0;
  int errors = 0;

  acc_job_arbiter #(
    .NUM_REQ(4), .WIDTH_TIMEOUT(8), .TIMEOUT_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .gnt_id_o(gnt_id_o),
    .acc_start_o(acc_start_o), .acc_done_i(acc_done_i), .acc_abort_o(acc_abort_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       start;
    logic       abort;
    logic       busy;
    logic [3:0] dn;
    logic       to;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] oh2id(input logic [3:0] v);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_start(output logic seen);
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk); #1;
      if (acc_start_o) seen = 1'b1;
      n++;
    end
    chk("start_seen", seen, 1);
  endtask

  // Expects a grant of exp, returns done in RUN cycle run_len, ends in IDLE.
  task automatic run_job(input logic [3:0] exp, input int run_len);
    logic seen;
    wait_start(seen);
    if (!seen) return;
    chk("grant", gnt_o, exp);
    chk("grant_id", gnt_id_o, oh2id(exp));
    repeat (run_len) @(negedge clk);
    acc_done_i = 1'b1;
    #1;
    chk("run_no_done", done_o, 0);
    @(negedge clk);
    acc_done_i = 1'b0;
    #1;
    chk("done_pulse", done_o, exp);
    chk("done_timeout", timeout_o, 0);
    chk("done_abort", acc_abort_o, 0);
    @(negedge clk); #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
  endtask

  initial begin
    logic seen;
    int   n;
    bit   fin;

    vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[2] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[3] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[4] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[5] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[6] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0};
    vecs[7] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[8] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};

    // Single job to requester 2, done three cycles into RUN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      req_i      = vecs[i].req;
      acc_done_i = vecs[i].done;
      #1;
      chk($sformatf("vec%0d", i),
          {gnt_o, gnt_id_o, acc_start_o, acc_abort_o, busy_o, done_o, timeout_o},
          {vecs[i].gnt, vecs[i].id, vecs[i].start, vecs[i].abort, vecs[i].busy,
           vecs[i].dn, vecs[i].to});
    end
    acc_done_i = 1'b0;

    // Fresh reset, all four requesting: rotation 0,1,2,3 then wrap to 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_i = 4'b1111;
    run_job(4'b0001, 1); req_i = 4'b1110;
    run_job(4'b0010, 2); req_i = 4'b1100;
    run_job(4'b0100, 3); req_i = 4'b1000;
    run_job(4'b1000, 1); req_i = 4'b0001;
    run_job(4'b0001, 2);

    // ptr = 1 with requesters 0 and 3: grant 3 first, then 0
    req_i = 4'b1001;
    run_job(4'b1000, 1); req_i = 4'b0001;
    run_job(4'b0001, 1); req_i = 4'b0010;

    // Watchdog: done never arrives, RUN lasts exactly 5 cycles
    wait_start(seen);
    req_i = 4'b0000;
    n = 0;
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk); #1;
      if (done_o != 0) fin = 1;
      else if (busy_o && !acc_start_o) n++;
      if (!fin) chk("run_no_abort", acc_abort_o, 0);
    end
    chk("wd_run_cycles", n, 5);
    chk("wd_done", done_o, 4'b0010);
    chk("wd_timeout", timeout_o, 1);
    chk("wd_abort", acc_abort_o, 1);
    @(negedge clk); #1;
    chk("wd_idle_busy", busy_o, 0);
    chk("wd_idle_timeout", timeout_o, 0);
    chk("wd_idle_abort", acc_abort_o, 0);

    // Done on the expiry cycle wins: no timeout
    req_i = 4'b0100;
    run_job(4'b0100, 5);

    // Done in IDLE is ignored
    req_i = 4'b0000;
    acc_done_i = 1'b1;
    @(negedge clk); #1;
    chk("idle_done_ignored_busy", busy_o, 0);
    chk("idle_done_ignored_gnt", gnt_o, 0);
    // Done held through IDLE and GRANT is ignored as well
    req_i = 4'b1000;
    @(negedge clk); #1;
    chk("grant_start", acc_start_o, 1);
    chk("grant_gnt", gnt_o, 4'b1000);
    @(negedge clk);
    acc_done_i = 1'b0;
    req_i = 4'b0000;
    #1;
    chk("run1_no_done", done_o, 0);
    chk("run1_busy", busy_o, 1);
    @(negedge clk); #1;
    chk("run2_no_done", done_o, 0);
    chk("run2_gnt", gnt_o, 4'b1000);
    acc_done_i = 1'b1;
    @(negedge clk);
    acc_done_i = 1'b0;
    #1;
    chk("late_done_pulse", done_o, 4'b1000);
    @(negedge clk); #1;
    chk("late_idle", busy_o, 0);

    // Move ptr to 2, then reset mid-RUN; ptr must restart at 0
    req_i = 4'b0010;
    run_job(4'b0010, 2);
    req_i = 4'b1100;
    wait_start(seen);
    chk("pre_rst_grant", gnt_o, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_outputs",
        {gnt_o, gnt_id_o, acc_start_o, acc_abort_o, busy_o, done_o, timeout_o}, 0);
    @(negedge clk); #1;
    chk("rst_no_done", done_o, 0);
    rst = 1'b0;
    req_i = 4'b1001;
    run_job(4'b0001, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
